delay_test: RTL and testbench
=============================

Name: delay_test

Overview:
- Small enable-gated delay line used to characterise register and pipeline timing in the Ethernet datapath.
- Captures a data word on enabled clock edges. Exposes two outputs:
  - out: first stage, one enabled edge of latency.
  - out2: last stage of a DEPTH-long enabled shift chain.
- Serves as the reference register-delay block for datapath alignment checks.

Parameters:
- WIDTH, 4, data width of in/out/out2 in bits (legal: >=1).
- DEPTH, 2, number of stages in the shift chain; out2 is stage DEPTH-1 (legal: >=2; elaboration error otherwise).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  shift enable; chain advances only on edges where en=1.
- in  input  WIDTH  data to capture.
- out  output  WIDTH  stage 0 of the chain (registered).
- out2  output  WIDTH  stage DEPTH-1 of the chain (registered).

Behaviour:
- State is stage[0..DEPTH-1], each WIDTH bits. out=stage[0], out2=stage[DEPTH-1]. Both outputs are direct register outputs with no combinational path from any input.
- Reset:
  - rst=1 at a rising edge sets every stage to 0, so out=0 and out2=0 after that edge.
  - rst has priority over en.
  - Reset mid-operation discards all in-flight data.
- Enabled edge (rst=0, en=1): stage[0]<=in and stage[k]<=stage[k-1] for k=1..DEPTH-1. All stages update simultaneously (true shift, non-blocking semantics).
- Disabled edge (rst=0, en=0): every stage holds; out and out2 keep their values indefinitely.
- Latency, counted in enabled edges not clock cycles:
  - out shows in one enabled edge after capture.
  - out2 shows it DEPTH enabled edges after capture.
  - With DEPTH=2, out2 equals the value out held before the latest enabled edge.
- Back-to-back en=1 gives one word per cycle; there is no backpressure or handshake.
- Inputs are sampled only at rising edges; glitches between edges have no effect.
- Before the first reset, register contents are X. Benches must apply reset first.

Optional Feature:
- Macro DELAY_TEST_FREERUN_EN.
- When defined:
  - Only stage[0] is gated by en.
  - Stages 1..DEPTH-1 shift on every non-reset edge (stage[k]<=stage[k-1] regardless of en).
  - out2 therefore shows out delayed by exactly DEPTH-1 clock cycles.
- When undefined (default): the whole chain is gated by en, as described in Behaviour.
- Reset behaviour is identical in both modes.

Decomposition:
- Package delay_test_pkg holds the WIDTH and DEPTH default constants and a localparam-style function that checks DEPTH>=2.
- One natural sub-module, delay_stage: a single WIDTH-bit register with sync active-high reset to 0 and a load enable.
- delay_test instantiates DEPTH delay_stage instances in a generate loop and selects the enables per the optional macro.

Test Plan:
- Reset: rst=1 for 2 edges with en=1, in=4'hF -> out=4'h0, out2=4'h0 after each edge.
- Capture: after reset, edge with en=1, in=4'b1010 -> out=4'b1010, out2=4'h0.
- Hold: next edge en=0, in=4'b0101 -> out stays 4'b1010, out2 stays 4'h0.
- Shift: next edge en=1, in=4'b0011 -> out=4'b0011, out2=4'b1010. Then 5 edges with en=0 -> both unchanged.
- Reset mid-stream: with out=4'b0011 and out2=4'b1010, edge with rst=1 and en=1 -> both 0. Next enabled edge with in=4'h6 -> out=4'h6, out2=4'h0.
- Free-run mode (DELAY_TEST_FREERUN_EN): en=1 with in=4'hA for one edge, then en=0 -> out=4'hA holds; out2=4'hA one cycle later despite en=0.

Source files
------------

// File: rtl/delay_test_pkg.sv
// Shared constants and elaboration helpers for the delay_test register-delay block.
// Holds the default data width and chain depth, and the legality check on depth.
package delay_test_pkg;

    // Default data width of the delay line in bits.
    localparam int WIDTH_DEFAULT = 4;

    // Default number of stages in the shift chain.
    localparam int DEPTH_DEFAULT = 2;

    // Shortest legal chain: out and out2 must be distinct stages.
    localparam int DEPTH_MIN = 2;

    // True when a chain depth is legal. Used in a constant context at elaboration.
    function automatic bit depth_ok(input int depth);
        return (depth >= DEPTH_MIN);
    endfunction

endpackage

// File: rtl/delay_test_stage.sv
// delay_stage: one WIDTH-bit register of the delay chain.
// Synchronous active-high reset clears the word; load selects capture versus hold.
module delay_stage
    import delay_test_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage register: reset wins, otherwise capture on load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WIDTH{1'b0}};
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/delay_test.sv
// delay_test: enable-gated delay line used as a reference register delay.
// out is stage 0 of the chain, out2 is the last stage (DEPTH-1).
// Optional macro DELAY_TEST_FREERUN_EN: only stage 0 is gated by en; the
// remaining stages shift on every non-reset edge, so out2 trails out by
// exactly DEPTH-1 clock cycles. Without the macro the whole chain is gated.
module delay_test
    import delay_test_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out2
);

    // Reject a chain too short to give distinct first and last stages.
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("delay_test: DEPTH must be at least 2");
    end

    // Stage outputs, index 0 is the capture stage.
    logic [WIDTH-1:0] stage_s [DEPTH];

    // Per-stage load enables.
    logic             load_s  [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            // The capture stage always follows the external enable.
            assign load_s[k] = en;

            delay_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .load (load_s[k]),
                .d    (in),
                .q    (stage_s[k])
            );
        end else begin : g_tail
`ifdef DELAY_TEST_FREERUN_EN
            // Trailing stages run every cycle so out2 is a fixed cycle delay of out.
            assign load_s[k] = 1'b1;
`else
            // Trailing stages advance together with the capture stage.
            assign load_s[k] = en;
`endif

            delay_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .load (load_s[k]),
                .d    (stage_s[k-1]),
                .q    (stage_s[k])
            );
        end
    end

    // Outputs come straight from stage registers; no input reaches them combinationally.
    assign out  = stage_s[0];
    assign out2 = stage_s[DEPTH-1];

endmodule

// File: tb/tb_delay_test.sv
// Self-checking bench for delay_test (default WIDTH=4, DEPTH=2).
// A queue-based model predicts out/out2 from the captured-word history and is
// compared against the DUT on every falling edge once reset has been applied;
// a few hand-computed literal checks pin the model. Honours DELAY_TEST_FREERUN_EN.
module tb_delay_test;

    localparam int W = 4;
    localparam int D = 2;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] din;
    logic [W-1:0] out;
    logic [W-1:0] out2;

    int n_vec;
    int n_err;
    bit model_valid;
    bit done;

    // Default mode: words captured on enabled edges since reset, newest first.
    // Free-run mode: value of out after each clock edge since reset, newest first.
    logic [W-1:0] hist[$];

    delay_test #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .in   (din),
        .out  (out),
        .out2 (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_out();
        if (hist.size() > 0) return hist[0];
        return {W{1'b0}};
    endfunction

    function automatic logic [W-1:0] model_out2();
        if (hist.size() >= D) return hist[D-1];
        return {W{1'b0}};
    endfunction

    // Apply one edge worth of inputs, update the model at the edge, return at the next falling edge.
    task automatic drive(input logic r, input logic e, input logic [W-1:0] d);
        logic [W-1:0] nxt;
        rst = r;
        en  = e;
        din = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
`ifdef DELAY_TEST_FREERUN_EN
            for (int i = 0; i < D; i++) hist.push_front({W{1'b0}});
`endif
            model_valid = 1'b1;
        end else begin
`ifdef DELAY_TEST_FREERUN_EN
            nxt = e ? d : hist[0];
            hist.push_front(nxt);
`else
            if (e) hist.push_front(d);
`endif
            if (hist.size() > D) void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic check_lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid && !done) begin
                n_vec++;
                if (out !== model_out() || out2 !== model_out2()) begin
                    n_err++;
                    $display("FAIL model: out=%h out2=%h expected out=%h out2=%h at %0t",
                             out, out2, model_out(), model_out2(), $time);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        model_valid = 1'b0;
        done = 1'b0;
        rst = 1'b1;
        en  = 1'b1;
        din = 4'hF;
        @(negedge clk);

        // Reset held two edges with en=1 and in=F.
        drive(1'b1, 1'b1, 4'hF);
        check_lit("rst1_out",  out,  4'h0);
        check_lit("rst1_out2", out2, 4'h0);
        drive(1'b1, 1'b1, 4'hF);
        check_lit("rst2_out",  out,  4'h0);
        check_lit("rst2_out2", out2, 4'h0);

        // Capture.
        drive(1'b0, 1'b1, 4'b1010);
        check_lit("cap_out",  out,  4'b1010);
        check_lit("cap_out2", out2, 4'h0);

        // Hold on a disabled edge.
        drive(1'b0, 1'b0, 4'b0101);
        check_lit("hold_out", out, 4'b1010);
`ifdef DELAY_TEST_FREERUN_EN
        check_lit("hold_out2", out2, 4'b1010);
`else
        check_lit("hold_out2", out2, 4'h0);
`endif

        // Shift.
        drive(1'b0, 1'b1, 4'b0011);
        check_lit("shift_out",  out,  4'b0011);
        check_lit("shift_out2", out2, 4'b1010);

        // Five disabled edges.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 4'(i + 8));
        check_lit("idle_out", out, 4'b0011);
`ifdef DELAY_TEST_FREERUN_EN
        check_lit("idle_out2", out2, 4'b0011);
`else
        check_lit("idle_out2", out2, 4'b1010);
`endif

        // Reset mid-stream, reset beats en.
        drive(1'b1, 1'b1, 4'hC);
        check_lit("mrst_out",  out,  4'h0);
        check_lit("mrst_out2", out2, 4'h0);
        drive(1'b0, 1'b1, 4'h6);
        check_lit("post_out",  out,  4'h6);
        check_lit("post_out2", out2, 4'h0);

        // One enabled edge with A, then a disabled edge.
        drive(1'b0, 1'b1, 4'hA);
        check_lit("fr_cap_out",  out,  4'hA);
        check_lit("fr_cap_out2", out2, 4'h6);
        drive(1'b0, 1'b0, 4'h0);
        check_lit("fr_hold_out", out, 4'hA);
`ifdef DELAY_TEST_FREERUN_EN
        check_lit("fr_hold_out2", out2, 4'hA);
`else
        check_lit("fr_hold_out2", out2, 4'h6);
`endif

        // Back-to-back and gapped enables, checked by the model every cycle.
        for (int i = 0; i < 24; i++) drive(1'b0, (i % 3) != 2, 4'(i * 5 + 1));

        // Reset again with data in flight, then a short stream.
        drive(1'b1, 1'b0, 4'h9);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 4'(15 - i));
        check_lit("end_out",  out,  4'hA);
        check_lit("end_out2", out2, 4'hB);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
